// File: rtl/lut_neuron_layer_pipe_if.sv
// Handshake, data and config bundle for the LUT neuron layer.
// The slave modport faces the layer; the master modport faces whoever feeds it.
interface lut_neuron_layer_pipe_if #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 4,
  parameter int NID_W       = 2
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
  logic                            cfg_we;
  logic [NID_W-1:0]                cfg_nid;
  logic [IN_BITS-1:0]              cfg_addr;
  logic [OUT_BITS-1:0]             cfg_data;
  logic                            cfg_ready;
  logic                            init_done;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_nid, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, init_done
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_nid, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, init_done
  );
endinterface

// File: rtl/lut_neuron_layer_pipe.sv
// Layer of run-time loadable truth-table neurons in distributed RAM.
// Tables are cleared after reset, then one beat per cycle is looked up with 1-cycle latency.
module lut_neuron_layer_pipe #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 4,
  parameter int NID_W       = 2
) (
  input logic clk,
  input logic rst,
  lut_neuron_layer_pipe_if.slave bus
);
  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                          state;
  logic [IN_BITS-1:0]              clr_cnt;
  logic                            out_valid_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q;
  logic                            cfg_ready_q;
  logic                            init_done_q;

  logic [OUT_BITS-1:0]             table_mem [NUM_NEURONS][DEPTH];

  logic                            in_ready_c;
  logic                            accept;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;

  assign in_ready_c = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  // Asynchronous read: a same-cycle config write is only seen by later beats.
  always_comb begin
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = table_mem[n][bus.in_data[n*IN_BITS +: IN_BITS]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      clr_cnt     <= '0;
      cfg_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state       <= RUN;
            cfg_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: state <= INIT;
      endcase

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lookup;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Neuron ids with no matching table simply never hit a write enable.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (!rst && state == INIT) begin
        table_mem[n][clr_cnt] <= '0;
      end else if (!rst && cfg_ready_q && bus.cfg_we && bus.cfg_nid == NID_W'(n)) begin
        table_mem[n][bus.cfg_addr] <= bus.cfg_data;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Directed bench for lut_neuron_layer_pipe: a 4-neuron instance for the main checks
// and a 3-neuron instance to show that out-of-range neuron ids are dropped.
module tb_lut_neuron_layer_pipe;
  logic clk;
  logic rst;

  int vectorsApplied = 0;
  int miscompares    = 0;

  lut_neuron_layer_pipe_if #(.IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(4), .NID_W(2)) bus ();
  lut_neuron_layer_pipe_if #(.IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(3), .NID_W(2)) bus3 ();

  lut_neuron_layer_pipe #(.IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(4), .NID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  lut_neuron_layer_pipe #(.IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(3), .NID_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorsApplied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat on the 4-neuron instance; result is sampled after the edge.
  task automatic applyStimulus(input logic [31:0] data);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic cfgWrite(input logic [1:0] nid, input logic [7:0] addr, input logic [1:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_nid  = nid;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfgWrite3(input logic [1:0] nid, input logic [7:0] addr, input logic [1:0] data);
    bus3.cfg_we   = 1'b1;
    bus3.cfg_nid  = nid;
    bus3.cfg_addr = addr;
    bus3.cfg_data = data;
    step();
    bus3.cfg_we = 1'b0;
  endtask

  logic [7:0] expBeat [4];
  logic [7:0] gotBeat [4];

  initial begin
    int   count;
    int   tx;
    int   rx;
    int   c;
    logic leak;
    logic stallLeak;

    expBeat[0] = 8'h0C;
    expBeat[1] = 8'h09;
    expBeat[2] = 8'h06;
    expBeat[3] = 8'h03;
    for (int i = 0; i < 4; i++) gotBeat[i] = '0;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_nid   = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b1;
    bus3.cfg_we    = 1'b0;
    bus3.cfg_nid   = '0;
    bus3.cfg_addr  = '0;
    bus3.cfg_data  = '0;

    repeat (3) step();
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("reset_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    checkOutput("reset_init_done", 32'(bus.init_done), 32'd0);

    // Run 100 INIT cycles with in_valid held, then reset in the middle of INIT.
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0000;
    leak = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready || bus.cfg_ready || bus.out_valid || bus.init_done) leak = 1'b1;
      step();
    end
    checkOutput("mid_init_blocked", 32'(leak), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    count = 0;
    leak  = 1'b0;
    while (!bus.init_done && count < 2000) begin
      if (bus.in_ready || bus.cfg_ready || bus.out_valid) leak = 1'b1;
      step();
      count++;
    end
    checkOutput("init_cycles",      32'(count),          32'd256);
    checkOutput("init_blocked",     32'(leak),           32'd0);
    checkOutput("init_cfg_ready",   32'(bus.cfg_ready),  32'd1);
    checkOutput("init_no_accept",   32'(bus.out_valid),  32'd0);
    checkOutput("init3_done",       32'(bus3.init_done), 32'd1);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("run_in_ready",     32'(bus.in_ready),   32'd1);

    applyStimulus(32'hFFD0_0000);
    checkOutput("clear_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("clear_data",  32'(bus.out_data),  32'h00);

    cfgWrite(2'd0, 8'hD0, 2'b00);
    cfgWrite(2'd1, 8'h30, 2'b01);
    cfgWrite(2'd2, 8'hC8, 2'b10);
    cfgWrite(2'd3, 8'h00, 2'b11);
    checkOutput("drained_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus({8'h00, 8'hC8, 8'h30, 8'hD0});
    checkOutput("load_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("load_data",  32'(bus.out_data),  32'hE4);

    // Beat k addresses entry k+1 in every neuron: neuron0 returns k, neuron1 returns 3-k.
    for (int k = 0; k < 4; k++) begin
      cfgWrite(2'd0, 8'(k + 1), 2'(k));
      cfgWrite(2'd1, 8'(k + 1), 2'(3 - k));
    end

    tx = 0;
    rx = 0;
    c  = 0;
    stallLeak = 1'b0;
    while (rx < 4 && c < 40) begin
      bus.out_ready = (c == 0 || c >= 4);
      bus.in_valid  = (tx < 4);
      bus.in_data   = {4{8'(tx + 1)}};
      #1;
      if (c >= 1 && c <= 3) begin
        if (bus.in_ready || !bus.out_valid || bus.out_data !== 8'h0C) stallLeak = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        gotBeat[rx] = bus.out_data;
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      @(posedge clk);
      #1;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("bp_stall_hold", 32'(stallLeak), 32'd0);
    checkOutput("bp_rx_count",   32'(rx),        32'd4);
    checkOutput("bp_cycles",     32'(c),         32'd8);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_beat%0d", i), 32'(gotBeat[i]), 32'(expBeat[i]));
    end
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_hold",  32'(bus.out_data),  32'h03);

    // Same-cycle write and lookup of neuron 0 entry 0x10.
    bus.cfg_we   = 1'b1;
    bus.cfg_nid  = 2'd0;
    bus.cfg_addr = 8'h10;
    bus.cfg_data = 2'b11;
    applyStimulus(32'h0000_0010);
    bus.cfg_we = 1'b0;
    checkOutput("collide_old", 32'(bus.out_data), 32'hC0);
    applyStimulus(32'h0000_0010);
    checkOutput("collide_new", 32'(bus.out_data), 32'hC3);

    cfgWrite3(2'd3, 8'h05, 2'b11);
    cfgWrite3(2'd0, 8'h05, 2'b01);
    bus3.in_data  = {3{8'h05}};
    bus3.in_valid = 1'b1;
    step();
    bus3.in_valid = 1'b0;
    checkOutput("badnid_valid", 32'(bus3.out_valid), 32'd1);
    checkOutput("badnid_data",  32'(bus3.out_data),  32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end
endmodule
